// File: rtl/neuron_pkg.sv
// Shared definitions for the synaptic accumulation datapath.
//   state_t   : scheduler states
//   clog2     : ceiling log2, never less than 1 so derived port widths stay legal
//   sat_clamp : clamps a sign-extended accumulator value to a signed w-bit range
package neuron_pkg;

  // Working width for clamp arithmetic; accumulators up to this width are supported.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    EMIT,
    DONE
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((SAT_W'(1) << r) < SAT_W'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_clamp(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Wide signed accumulator with a saturated narrow view.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (takes priority over add_en)
//   add_en     : add sign-extended add_data this cycle
//   add_data   : signed WIDTH-bit addend
//   sum        : accumulator clamped to the signed WIDTH-bit range
module sat_accumulator
  import neuron_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [WIDTH-1:0] add_data,
  output logic [WIDTH-1:0] sum
);

  logic signed [ACC_WIDTH-1:0] acc;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + ACC_WIDTH'($signed(add_data));
    end
  end

  assign sum = WIDTH'(sat_clamp(SAT_W'(acc), WIDTH));

endmodule

// File: rtl/synapse_accum_sched.sv
// Time-multiplexed synaptic accumulation scheduler. One shared accumulator
// walks every neuron (outer) and synapse (inner) through an external
// synchronous weight memory, summing weights of spiking synapses and
// emitting one saturated sum per neuron over a valid/ready handshake.
//   clk, reset           : clock, synchronous active-high reset
//   start, spike_in      : pass request and presynaptic mask (sampled when idle)
//   busy, done           : pass in progress / one-cycle completion pulse
//   w_rd_en, w_rd_addr   : weight read strobe and address (neuron*N_SYN + syn)
//   w_rd_data            : weight returned one cycle after w_rd_en
//   sum_valid, sum_ready : per-neuron result handshake
//   sum_neuron, sum_data : neuron index and saturated sum
module synapse_accum_sched
  import neuron_pkg::*;
#(
  parameter int unsigned N_NEURON  = 256,
  parameter int unsigned N_SYN     = 256,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ACC_WIDTH = WIDTH + clog2(N_SYN)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [N_SYN-1:0]                   spike_in,
  output logic                               busy,
  output logic                               done,
  output logic                               w_rd_en,
  output logic [clog2(N_NEURON*N_SYN)-1:0]   w_rd_addr,
  input  logic [WIDTH-1:0]                   w_rd_data,
  output logic                               sum_valid,
  input  logic                               sum_ready,
  output logic [clog2(N_NEURON)-1:0]         sum_neuron,
  output logic [WIDTH-1:0]                   sum_data
);

  localparam int unsigned ADDR_W = clog2(N_NEURON * N_SYN);
  localparam int unsigned NEU_W  = clog2(N_NEURON);
  localparam int unsigned SYN_W  = clog2(N_SYN);

  state_t             state;
  logic [N_SYN-1:0]   spike_reg;
  logic [SYN_W-1:0]   syn;
  logic [NEU_W-1:0]   neuron;
  logic               rd_pend;
  logic               acc_clear;
  logic [WIDTH-1:0]   sat_sum;

  // Accumulator restarts on an accepted start and after each sum handshake.
  always_comb begin
    acc_clear = 1'b0;
    if ((state == IDLE) && start) acc_clear = 1'b1;
    if ((state == EMIT) && sum_ready) acc_clear = 1'b1;
  end

  sat_accumulator #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (acc_clear),
    .add_en   (rd_pend),
    .add_data (w_rd_data),
    .sum      (sat_sum)
  );

  assign sum_data = sum_valid ? sat_sum : '0;

  // Outputs are registered alongside the state update, so each one is set on
  // the transition into the state where it must be observed. The read address
  // is a running counter: the neuron-major walk makes it contiguous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      spike_reg  <= '0;
      syn        <= '0;
      neuron     <= '0;
      rd_pend    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      w_rd_en    <= 1'b0;
      w_rd_addr  <= '0;
      sum_valid  <= 1'b0;
      sum_neuron <= '0;
    end else begin
      rd_pend <= w_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            spike_reg <= spike_in;
            syn       <= '0;
            neuron    <= '0;
            busy      <= 1'b1;
            w_rd_en   <= spike_in[0];
            w_rd_addr <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (syn == SYN_W'(N_SYN - 1)) begin
            syn     <= '0;
            w_rd_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            syn       <= syn + SYN_W'(1);
            w_rd_en   <= spike_reg[syn + SYN_W'(1)];
            w_rd_addr <= w_rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          sum_valid  <= 1'b1;
          sum_neuron <= neuron;
          state      <= EMIT;
        end
        EMIT: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            if (neuron == NEU_W'(N_NEURON - 1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              neuron    <= neuron + NEU_W'(1);
              w_rd_en   <= spike_reg[0];
              w_rd_addr <= w_rd_addr + ADDR_W'(1);
              state     <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_accum_sched.sv
module tb_synapse_accum_sched;

  localparam int unsigned N_NEURON = 4;
  localparam int unsigned N_SYN    = 8;
  localparam int unsigned WIDTH    = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  spike_in;
  logic        busy;
  logic        done;
  logic        w_rd_en;
  logic [4:0]  w_rd_addr;
  logic [15:0] w_rd_data;
  logic        sum_valid;
  logic        sum_ready;
  logic [1:0]  sum_neuron;
  logic [15:0] sum_data;

  synapse_accum_sched #(
    .N_NEURON (N_NEURON),
    .N_SYN    (N_SYN),
    .WIDTH    (WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .spike_in   (spike_in),
    .busy       (busy),
    .done       (done),
    .w_rd_en    (w_rd_en),
    .w_rd_addr  (w_rd_addr),
    .w_rd_data  (w_rd_data),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_neuron (sum_neuron),
    .sum_data   (sum_data)
  );

  typedef struct {
    int neuron;
    int data;
  } sum_exp_t;

  sum_exp_t    sum_q[$];
  int          addr_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          start_cyc = 0;
  logic [15:0] mem [0:31];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous weight memory: data valid the cycle after the strobe.
  initial w_rd_data = '0;
  always @(posedge clk) if (w_rd_en) w_rd_data <= mem[w_rd_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string why);
    n_total++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Monitor: reads must match the expected address order; every presented
  // sum is compared against the queue head, popped only on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (w_rd_en) begin
        if (addr_q.size() == 0) fail_now("rd_addr", "read issued with none expected");
        else check("rd_addr", longint'(w_rd_addr), longint'(addr_q.pop_front()));
      end
      if (sum_valid) begin
        if (sum_q.size() == 0) begin
          fail_now("sum", "unexpected sum_valid");
        end else begin
          check("sum_neuron", longint'(sum_neuron), longint'(sum_q[0].neuron));
          check("sum_data", longint'($signed(sum_data)), longint'(sum_q[0].data));
          if (sum_ready) void'(sum_q.pop_front());
          else check("stall_no_read", longint'(w_rd_en), 0);
        end
      end
    end
  end

  task automatic load_weights(input int mode);
    for (int n = 0; n < 4; n++)
      for (int s = 0; s < 8; s++)
        mem[n*8+s] = (mode == 0) ? 16'(n + s) : ((mode == 1) ? 16'h7FFF : 16'h8000);
  endtask

  task automatic push_expect(input logic [7:0] mask, input int e0, input int e1,
                             input int e2, input int e3);
    int e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int n = 0; n < 4; n++) begin
      for (int s = 0; s < 8; s++) if (mask[s]) addr_q.push_back(n*8 + s);
      sum_q.push_back('{n, e[n]});
    end
  endtask

  task automatic issue_start(input logic [7:0] mask);
    @(negedge clk);
    start     = 1'b1;
    spike_in  = mask;
    start_cyc = cyc;
    @(negedge clk);
    start    = 1'b0;
    spike_in = ~mask;
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check({tag, "_latency"}, longint'(cyc - start_cyc), longint'(exp_lat));
        check({tag, "_busy_in_done"}, longint'(busy), 1);
      end
    end
    if (!seen) begin
      fail_now(tag, "timeout waiting for done");
    end else begin
      @(negedge clk);
      check({tag, "_done_pulse"}, longint'(done), 0);
      check({tag, "_busy_after"}, longint'(busy), 0);
    end
    check({tag, "_sums_left"}, longint'(sum_q.size()), 0);
    check({tag, "_reads_left"}, longint'(addr_q.size()), 0);
  endtask

  task automatic run_pass(input logic [7:0] mask, input int e0, input int e1,
                          input int e2, input int e3, input int lat, input string tag);
    push_expect(mask, e0, e1, e2, e3);
    issue_start(mask);
    wait_done(lat, tag);
  endtask

  task automatic stall_n1();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (sum_valid && sum_neuron == 2'd1) begin
        got = 1'b1;
        sum_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 sum_ready = 1'b1;
      end
    end
    if (!got) fail_now("stall", "neuron 1 sum never presented");
  endtask

  initial begin
    int extra;
    reset     = 1'b1;
    start     = 1'b0;
    spike_in  = '0;
    sum_ready = 1'b1;
    load_weights(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_rd_en", longint'(w_rd_en), 0);
    check("rst_rd_addr", longint'(w_rd_addr), 0);
    check("rst_sum_valid", longint'(sum_valid), 0);
    check("rst_sum_neuron", longint'(sum_neuron), 0);
    check("rst_sum_data", longint'(sum_data), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_pass(8'hFF, 28, 36, 44, 52, 41, "full");
    run_pass(8'h05, 2, 4, 6, 8, 41, "sparse");
    run_pass(8'h00, 0, 0, 0, 0, 41, "nospike");
    load_weights(1);
    run_pass(8'hFF, 32767, 32767, 32767, 32767, 41, "sat_pos");
    load_weights(2);
    run_pass(8'hFF, -32768, -32768, -32768, -32768, 41, "sat_neg");
    load_weights(0);

    fork
      run_pass(8'hFF, 28, 36, 44, 52, 46, "stall");
      stall_n1();
    join

    fork
      run_pass(8'h05, 2, 4, 6, 8, 41, "busy_start");
      begin
        repeat (6) @(negedge clk);
        check("busy_at_restart", longint'(busy), 1);
        start    = 1'b1;
        spike_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
      end
    join
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("busy_start_single_done", longint'(extra), 0);

    // Reset (with a simultaneous start) during FETCH of neuron 2.
    push_expect(8'hFF, 28, 36, 44, 52);
    issue_start(8'hFF);
    repeat (22) @(posedge clk);
    #1;
    reset    = 1'b1;
    start    = 1'b1;
    spike_in = 8'h0F;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    sum_q.delete();
    addr_q.delete();
    @(negedge clk);
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_rd_en", longint'(w_rd_en), 0);
    check("abort_rd_addr", longint'(w_rd_addr), 0);
    check("abort_sum_valid", longint'(sum_valid), 0);
    check("abort_sum_data", longint'(sum_data), 0);
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort_no_done", longint'(extra), 0);
    run_pass(8'hFF, 28, 36, 44, 52, 41, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
